// File: rtl/streaming_width_converter.sv
// AXI-Stream width converter: splits each input word into LSB-first output beats (downsize),
// packs input words LSB-first into one output beat (upsize), or acts as a register slice (equal).
//
// Downsize FSM:
//   state    | meaning
//   ST_EMPTY | holding register free, output idle
//   ST_EMIT  | holding register loaded, slice idx_q presented on the output
module streaming_width_converter #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY
);

  localparam int R  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH / OUT_WIDTH : OUT_WIDTH / IN_WIDTH;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  if ((IN_WIDTH % OUT_WIDTH != 0) && (OUT_WIDTH % IN_WIDTH != 0)) begin : g_bad_ratio
    $error("streaming_width_converter: widths must be integer multiples of each other");
  end

  if (IN_WIDTH > OUT_WIDTH) begin : g_down
    typedef enum logic {ST_EMPTY, ST_EMIT} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic                last_slice, in_acc, out_acc;

    always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      last_slice = (idx_q == CW'(R - 1));
      // Last slice leaving frees the register in the same cycle, so the next word loads without a bubble.
      in0_V_V_TREADY = ap_rst_n && ((state_q == ST_EMPTY) || (out_V_V_TREADY && last_slice));
      out_V_V_TVALID = (state_q == ST_EMIT);
      out_V_V_TDATA  = hold_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
      in_acc  = in0_V_V_TVALID && in0_V_V_TREADY;
      out_acc = out_V_V_TVALID && out_V_V_TREADY;
      if (out_acc) begin
        if (last_slice) begin
          idx_d   = '0;
          state_d = ST_EMPTY;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      if (in_acc) begin
        hold_d  = in0_V_V_TDATA;
        state_d = ST_EMIT;
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        state_q <= ST_EMPTY;
        idx_q   <= '0;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        hold_q  <= hold_d;
      end
    end
  end else if (OUT_WIDTH > IN_WIDTH) begin : g_up
    logic [(R-1)*IN_WIDTH-1:0] pack_q, pack_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]      data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      in_acc, out_acc;

    always_comb begin
      pack_d  = pack_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      in0_V_V_TREADY = ap_rst_n && (!valid_q || out_V_V_TREADY);
      out_V_V_TVALID = valid_q;
      out_V_V_TDATA  = data_q;
      in_acc  = in0_V_V_TVALID && in0_V_V_TREADY;
      out_acc = valid_q && out_V_V_TREADY;
      if (out_acc) valid_d = 1'b0;
      if (in_acc) begin
        if (cnt_q == CW'(R - 1)) begin
          // Final word bypasses the pack register straight into the top of the output beat.
          data_d  = {in0_V_V_TDATA, pack_q};
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          pack_d[cnt_q*IN_WIDTH +: IN_WIDTH] = in0_V_V_TDATA;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        pack_q  <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        pack_q  <= pack_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end
  end else begin : g_pass
    logic [OUT_WIDTH-1:0] data_q;
    logic                 valid_q;

    always_comb begin
      in0_V_V_TREADY = ap_rst_n && (!valid_q || out_V_V_TREADY);
      out_V_V_TVALID = valid_q;
      out_V_V_TDATA  = data_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (in0_V_V_TREADY) begin
        valid_q <= in0_V_V_TVALID;
        if (in0_V_V_TVALID) data_q <= in0_V_V_TDATA;
      end
    end
  end

endmodule

// File: tb/tb_streaming_width_converter.sv
// Bench for streaming_width_converter: directed scenarios on a 24->8 and an 8->24 instance,
// then a randomized soak against queue-based byte-stream reference models.
module tb_streaming_width_converter;

  localparam int N_SOAK = 10000;
  localparam int BUDGET = 90000;

  logic        clk, rst_n;
  logic [23:0] d_in_data;
  logic        d_in_valid, d_in_ready;
  logic [7:0]  d_out_data;
  logic        d_out_valid, d_out_ready;
  logic [7:0]  u_in_data;
  logic        u_in_valid, u_in_ready;
  logic [23:0] u_out_data;
  logic        u_out_valid, u_out_ready;

  int vectors = 0;
  int miscompares = 0;

  streaming_width_converter #(.IN_WIDTH(24), .OUT_WIDTH(8)) dut_down (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(d_in_data), .in0_V_V_TVALID(d_in_valid), .in0_V_V_TREADY(d_in_ready),
    .out_V_V_TDATA(d_out_data), .out_V_V_TVALID(d_out_valid), .out_V_V_TREADY(d_out_ready)
  );

  streaming_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(24)) dut_up (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(u_in_data), .in0_V_V_TVALID(u_in_valid), .in0_V_V_TREADY(u_in_ready),
    .out_V_V_TDATA(u_out_data), .out_V_V_TVALID(u_out_valid), .out_V_V_TREADY(u_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    d_in_valid = 1'b1; d_in_data = 24'h5A5A5A; d_out_ready = 1'b1;
    u_in_valid = 1'b1; u_in_data = 8'hA5;      u_out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      vectors++;
      if (d_out_valid !== 1'b0 || d_in_ready !== 1'b0 || d_out_data !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_down: valid=%b ready=%b data=%h, expected 0 0 00", d_out_valid, d_in_ready, d_out_data);
      end
      vectors++;
      if (u_out_valid !== 1'b0 || u_in_ready !== 1'b0 || u_out_data !== 24'h0) begin
        miscompares++;
        $display("FAIL reset_up: valid=%b ready=%b data=%h, expected 0 0 000000", u_out_valid, u_in_ready, u_out_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; d_in_valid = 1'b0; u_in_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (d_in_ready !== 1'b1 || u_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: down=%b up=%b, expected 1 1", d_in_ready, u_in_ready);
    end
    vectors++;
    if (d_out_valid !== 1'b0 || u_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_valid: down=%b up=%b, expected 0 0", d_out_valid, u_out_valid);
    end
  endtask

  task automatic test_down_back_to_back();
    logic [23:0] w [2];
    logic [7:0]  exp [6];
    int sent;
    w   = '{24'hCCBBAA, 24'h332211};
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
    @(negedge clk);
    d_out_ready = 1'b1; d_in_valid = 1'b1; d_in_data = w[0]; #1;
    vectors++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_accept: ready=%b valid=%b, expected 1 0", d_in_ready, d_out_valid);
    end
    sent = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d_in_valid = (sent < 2);
      if (sent < 2) d_in_data = w[sent];
      #1;
      vectors++;
      if (d_out_valid !== 1'b1 || d_out_data !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: valid=%b data=%h, expected 1 %h", i, d_out_valid, d_out_data, exp[i]);
      end
      if (d_in_valid && d_in_ready) sent++;
    end
    @(negedge clk); d_in_valid = 1'b0; #1;
    vectors++;
    if (d_out_valid !== 1'b0 || sent != 2) begin
      miscompares++;
      $display("FAIL b2b_end: valid=%b words_taken=%0d, expected 0 2", d_out_valid, sent);
    end
  endtask

  task automatic test_down_backpressure();
    logic       rdy [5];
    logic [7:0] exp [5];
    logic       exp_tr [5];
    logic [7:0] drain [3];
    rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp    = '{8'h12, 8'h34, 8'h34, 8'h34, 8'h56};
    exp_tr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drain  = '{8'hEF, 8'hCD, 8'hAB};
    @(negedge clk);
    d_in_valid = 1'b1; d_in_data = 24'h563412; d_out_ready = 1'b0; #1;
    vectors++;
    if (d_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: ready=%b, expected 1", d_in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_in_valid = 1'b1; d_in_data = 24'hABCDEF; d_out_ready = rdy[i]; #1;
      vectors++;
      if (d_out_valid !== 1'b1 || d_out_data !== exp[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d: valid=%b data=%h, expected 1 %h", i, d_out_valid, d_out_data, exp[i]);
      end
      vectors++;
      if (d_in_ready !== exp_tr[i]) begin
        miscompares++;
        $display("FAIL bp_in_ready%0d: got %b, expected %b", i, d_in_ready, exp_tr[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_in_valid = 1'b0; d_out_ready = 1'b1; #1;
      vectors++;
      if (d_out_valid !== 1'b1 || d_out_data !== drain[i]) begin
        miscompares++;
        $display("FAIL bp_drain%0d: valid=%b data=%h, expected 1 %h", i, d_out_valid, d_out_data, drain[i]);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: valid=%b, expected 0", d_out_valid);
    end
  endtask

  task automatic test_up_gaps();
    logic       vld [4];
    logic [7:0] dat [4];
    vld = '{1'b1, 1'b0, 1'b1, 1'b1};
    dat = '{8'h01, 8'hEE, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_out_ready = 1'b1; u_in_valid = vld[i]; u_in_data = dat[i]; #1;
      vectors++;
      if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL up_gap_cycle%0d: ready=%b valid=%b, expected 1 0", i, u_in_ready, u_out_valid);
      end
    end
    @(negedge clk); u_in_valid = 1'b0; #1;
    vectors++;
    if (u_out_valid !== 1'b1 || u_out_data !== 24'h030201) begin
      miscompares++;
      $display("FAIL up_gap_beat: valid=%b data=%h, expected 1 030201", u_out_valid, u_out_data);
    end
    @(negedge clk); #1;
    vectors++;
    if (u_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL up_gap_single: valid=%b, expected 0", u_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3];
    exp = '{8'h02, 8'h01, 8'h00};
    @(negedge clk);
    d_in_valid = 1'b1; d_in_data = 24'hFFEEDD; d_out_ready = 1'b1;
    @(negedge clk); d_in_valid = 1'b0; #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_out_data !== 8'hDD) begin
      miscompares++;
      $display("FAIL mid_slice0: valid=%b data=%h, expected 1 dd", d_out_valid, d_out_data);
    end
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    vectors++;
    if (d_out_valid !== 1'b0 || d_out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_drop: valid=%b data=%h, expected 0 00", d_out_valid, d_out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; d_in_valid = 1'b1; d_in_data = 24'h000102; #1;
    vectors++;
    if (d_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_post_ready: got %b, expected 1", d_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d_in_valid = 1'b0; #1;
      vectors++;
      if (d_out_valid !== 1'b1 || d_out_data !== exp[i]) begin
        miscompares++;
        $display("FAIL mid_post_beat%0d: valid=%b data=%h, expected 1 %h", i, d_out_valid, d_out_data, exp[i]);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_post_idle: valid=%b, expected 0 (stale slice)", d_out_valid);
    end
  endtask

  task automatic test_soak();
    logic [7:0]  d_q [$];
    logic [23:0] u_q [$];
    logic [7:0]  u_acc [$];
    logic [7:0]  d_exp, d_prev;
    logic [23:0] u_exp, u_prev;
    logic        d_stall, u_stall, d_took, u_took;
    int d_sent, u_sent, d_got, u_got, cyc;
    d_sent = 0; u_sent = 0; d_got = 0; u_got = 0; cyc = 0;
    d_stall = 1'b0; u_stall = 1'b0; d_took = 1'b0; u_took = 1'b0;
    d_prev = '0; u_prev = '0;
    d_in_valid = 1'b0; u_in_valid = 1'b0;
    while ((d_got < 3*N_SOAK || u_got < N_SOAK/3) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (d_took) d_in_valid = 1'b0;
      if (u_took) u_in_valid = 1'b0;
      if (!d_in_valid && d_sent < N_SOAK && $urandom_range(1) == 1) begin
        d_in_valid = 1'b1; d_in_data = 24'($urandom);
      end
      if (!u_in_valid && u_sent < N_SOAK && $urandom_range(1) == 1) begin
        u_in_valid = 1'b1; u_in_data = 8'($urandom);
      end
      d_out_ready = 1'($urandom_range(1));
      u_out_ready = 1'($urandom_range(1));
      #1;
      if (d_stall) begin
        vectors++;
        if (d_out_valid !== 1'b1 || d_out_data !== d_prev) begin
          miscompares++;
          $display("FAIL soak_down_hold: valid=%b data=%h, expected 1 %h", d_out_valid, d_out_data, d_prev);
        end
      end
      if (d_out_valid && d_out_ready) begin
        vectors++;
        d_exp = (d_q.size() != 0) ? d_q.pop_front() : 8'hxx;
        if (d_out_data !== d_exp) begin
          miscompares++;
          $display("FAIL soak_down_data: beat %0d got %h, expected %h", d_got, d_out_data, d_exp);
        end
        d_got++;
      end
      d_stall = d_out_valid && !d_out_ready;
      d_prev  = d_out_data;
      d_took  = d_in_valid && d_in_ready;
      if (d_took) begin
        d_q.push_back(d_in_data[7:0]);
        d_q.push_back(d_in_data[15:8]);
        d_q.push_back(d_in_data[23:16]);
        d_sent++;
      end
      if (u_stall) begin
        vectors++;
        if (u_out_valid !== 1'b1 || u_out_data !== u_prev) begin
          miscompares++;
          $display("FAIL soak_up_hold: valid=%b data=%h, expected 1 %h", u_out_valid, u_out_data, u_prev);
        end
      end
      if (u_out_valid && u_out_ready) begin
        vectors++;
        u_exp = (u_q.size() != 0) ? u_q.pop_front() : 24'hxxxxxx;
        if (u_out_data !== u_exp) begin
          miscompares++;
          $display("FAIL soak_up_data: beat %0d got %h, expected %h", u_got, u_out_data, u_exp);
        end
        u_got++;
      end
      u_stall = u_out_valid && !u_out_ready;
      u_prev  = u_out_data;
      u_took  = u_in_valid && u_in_ready;
      if (u_took) begin
        u_acc.push_back(u_in_data);
        u_sent++;
        if (u_acc.size() == 3) begin
          u_q.push_back({u_acc[2], u_acc[1], u_acc[0]});
          u_acc.delete();
        end
      end
    end
    @(negedge clk);
    d_in_valid = 1'b0; u_in_valid = 1'b0;
    vectors++;
    if (cyc >= BUDGET || d_got != 3*N_SOAK || u_got != N_SOAK/3 || d_q.size() != 0 || u_q.size() != 0) begin
      miscompares++;
      $display("FAIL soak_complete: cycles=%0d down_beats=%0d up_beats=%0d left=%0d/%0d, expected down=%0d up=%0d left=0/0",
               cyc, d_got, u_got, d_q.size(), u_q.size(), 3*N_SOAK, N_SOAK/3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
    u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b0;
    test_reset();
    test_down_back_to_back();
    test_down_backpressure();
    test_up_gaps();
    test_reset_mid();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
